// File: rtl/spi_mem_target.sv
// SPI mode-0 serial-memory target: 0x03 read / 0x02 write, 24-bit big-endian
// address with per-byte auto-increment, bridged to a byte-wide memory port.
module spi_mem_target #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_clk,
  input  logic        spi_cs_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_oe,
  output logic [23:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_rdata,
  output logic        mem_wr,
  output logic [7:0]  mem_wdata,
  output logic        busy,
  output logic        bad_cmd
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, RD_DATA, WR_DATA, IGNORE} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_prev;
  logic                   cs_prev;
  logic                   sclk_s;
  logic                   cs_s;
  logic                   mosi_s;
  logic                   rise;
  logic                   fall;
  logic                   cs_fall;
  logic [4:0]             bit_cnt;
  logic [7:0]             shift;
  logic [7:0]             shift_in;
  logic                   is_read;
  logic                   rd_cap;
  logic [7:0]             rd_buf;
  logic [7:0]             tx;

  // CS synchronizer resets to "selected" so a frame already in progress at
  // reset release is not mistaken for a fresh falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      sclk_prev <= sclk_sync[SYNC_STAGES-1];
      cs_prev   <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s   = sclk_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign rise     = sclk_s & ~sclk_prev;
  assign fall     = ~sclk_s & sclk_prev;
  assign cs_fall  = ~cs_s & cs_prev;
  assign shift_in = {shift[6:0], mosi_s};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      spi_miso    <= 1'b0;
      spi_miso_oe <= 1'b0;
      mem_addr    <= '0;
      mem_rd      <= 1'b0;
      mem_wr      <= 1'b0;
      mem_wdata   <= '0;
      busy        <= 1'b0;
      bad_cmd     <= 1'b0;
      bit_cnt     <= '0;
      shift       <= '0;
      is_read     <= 1'b0;
      rd_cap      <= 1'b0;
      rd_buf      <= '0;
      tx          <= '0;
    end else begin
      mem_rd  <= 1'b0;
      mem_wr  <= 1'b0;
      bad_cmd <= 1'b0;
      // Read data returns one cycle after the strobe.
      rd_cap  <= mem_rd;
      if (rd_cap) rd_buf <= mem_rdata;
      // Write address advances after the strobe cycle that used it.
      if (mem_wr) mem_addr <= mem_addr + 24'd1;

      if (cs_s) begin
        state       <= IDLE;
        busy        <= 1'b0;
        spi_miso    <= 1'b0;
        spi_miso_oe <= 1'b0;
        rd_cap      <= 1'b0;
        bit_cnt     <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (cs_fall) begin
              state   <= CMD;
              bit_cnt <= '0;
              busy    <= 1'b1;
            end
          end
          CMD: begin
            if (rise) begin
              shift <= shift_in;
              if (bit_cnt == 5'd7) begin
                bit_cnt <= '0;
                if (shift_in == 8'h03 || shift_in == 8'h02) begin
                  state   <= ADDR;
                  is_read <= (shift_in == 8'h03);
                end else begin
                  state   <= IGNORE;
                  bad_cmd <= 1'b1;
                end
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          end
          ADDR: begin
            if (rise) begin
              mem_addr <= {mem_addr[22:0], mosi_s};
              if (bit_cnt == 5'd23) begin
                bit_cnt <= '0;
                if (is_read) begin
                  state  <= RD_DATA;
                  mem_rd <= 1'b1;
                end else begin
                  state <= WR_DATA;
                end
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          end
          RD_DATA: begin
            if (rise) begin
              if (bit_cnt == 5'd7) begin
                bit_cnt  <= '0;
                mem_addr <= mem_addr + 24'd1;
                mem_rd   <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end else if (fall) begin
              spi_miso_oe <= 1'b1;
              // A fall at bit 0 starts a new byte from the prefetched data.
              if (bit_cnt == 5'd0) begin
                spi_miso <= rd_buf[7];
                tx       <= {rd_buf[6:0], 1'b0};
              end else begin
                spi_miso <= tx[7];
                tx       <= {tx[6:0], 1'b0};
              end
            end
          end
          WR_DATA: begin
            if (rise) begin
              shift <= shift_in;
              if (bit_cnt == 5'd7) begin
                bit_cnt   <= '0;
                mem_wdata <= shift_in;
                mem_wr    <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          end
          IGNORE: begin
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_mem_target.sv
// Bench for spi_mem_target: SPI master tasks, a byte memory model, and a
// scoreboard of expected memory/bad_cmd strobes checked by a monitor.
module tb_spi_mem_target;

  localparam int HALF = 8;
  localparam logic [1:0] K_RD = 2'd0, K_WR = 2'd1, K_BAD = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [23:0] addr;
    logic [7:0]  data;
  } ev_t;

  logic        clk;
  logic        rst;
  logic        spi_clk;
  logic        spi_cs_n;
  logic        spi_mosi;
  logic        spi_miso;
  logic        spi_miso_oe;
  logic [23:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_rdata;
  logic        mem_wr;
  logic [7:0]  mem_wdata;
  logic        busy;
  logic        bad_cmd;

  logic [7:0]  mem [logic [23:0]];
  ev_t         exp_q [$];
  ev_t         mon_act;
  ev_t         mon_exp;
  int          checks;
  int          errors;
  int          oe_cnt;
  int          oe_before;

  spi_mem_target #(.SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .spi_clk     (spi_clk),
    .spi_cs_n    (spi_cs_n),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .mem_addr    (mem_addr),
    .mem_rd      (mem_rd),
    .mem_rdata   (mem_rdata),
    .mem_wr      (mem_wr),
    .mem_wdata   (mem_wdata),
    .busy        (busy),
    .bad_cmd     (bad_cmd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] mem_read(input logic [23:0] a);
    if (mem.exists(a)) return mem[a];
    return 8'h00;
  endfunction

  // Memory model: registered read, one-cycle latency; writes update the model.
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem_read(mem_addr);
    if (mem_wr) mem[mem_addr] = mem_wdata;
  end

  function automatic ev_t mk(input logic [1:0] k, input logic [23:0] a, input logic [7:0] d);
    ev_t e;
    e.kind = k;
    e.addr = a;
    e.data = d;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic spi_byte(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = tx[7-i];
      wait_clk(HALF);
      spi_clk = 1'b1;
      rx = {rx[6:0], spi_miso};
      wait_clk(HALF);
      spi_clk = 1'b0;
    end
  endtask

  task automatic cs_low();
    spi_cs_n = 1'b0;
    wait_clk(HALF);
    chk("busy_selected", {31'd0, busy}, 32'd1);
  endtask

  task automatic cs_high(input string name);
    wait_clk(HALF);
    spi_cs_n = 1'b1;
    wait_clk(HALF);
    chk({name, "_oe_after_cs"}, {31'd0, spi_miso_oe}, 32'd0);
    chk({name, "_busy_after_cs"}, {31'd0, busy}, 32'd0);
    chk({name, "_queue_drained"}, exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  task automatic send_hdr(input logic [7:0] cmd, input logic [23:0] addr);
    logic [7:0] rx;
    spi_byte(cmd, 8, rx);
    spi_byte(addr[23:16], 8, rx);
    spi_byte(addr[15:8], 8, rx);
    spi_byte(addr[7:0], 8, rx);
  endtask

  task automatic do_read(input string name, input logic [23:0] addr, input int n,
                         input logic [31:0] exp_bytes);
    logic [7:0] rx;
    cs_low();
    exp_q.push_back(mk(K_RD, addr, 8'h00));
    send_hdr(8'h03, addr);
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(mk(K_RD, addr + 24'(k + 1), 8'h00));
      spi_byte(8'h00, 8, rx);
      chk({name, "_rx_byte"}, {24'd0, rx}, {24'd0, 8'(exp_bytes >> (24 - 8 * k))});
    end
    cs_high(name);
  endtask

  task automatic do_write(input string name, input logic [23:0] addr, input int n,
                          input logic [31:0] data);
    logic [7:0] rx;
    logic [7:0] b;
    cs_low();
    send_hdr(8'h02, addr);
    for (int k = 0; k < n; k++) begin
      b = 8'(data >> (24 - 8 * k));
      exp_q.push_back(mk(K_WR, addr + 24'(k), b));
      spi_byte(b, 8, rx);
    end
    cs_high(name);
  endtask

  initial begin
    logic [7:0] rx;
    checks   = 0;
    errors   = 0;
    oe_cnt   = 0;
    rst      = 1'b1;
    spi_clk  = 1'b0;
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    mem[24'h000100] = 8'h11;
    mem[24'h000101] = 8'h22;
    mem[24'h000102] = 8'h33;
    mem[24'h000103] = 8'h44;
    mem[24'hFFFFFE] = 8'hC1;
    mem[24'hFFFFFF] = 8'hC2;
    mem[24'h000000] = 8'hC3;
    mem[24'h000001] = 8'hC4;

    fork
      begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
      end
      forever begin
        @(negedge clk);
        if (spi_miso_oe) oe_cnt++;
        if (!rst && (mem_rd || mem_wr || bad_cmd)) begin
          mon_act.kind = mem_wr ? K_WR : (mem_rd ? K_RD : K_BAD);
          mon_act.addr = bad_cmd ? 24'd0 : mem_addr;
          mon_act.data = mem_wr ? mem_wdata : 8'h00;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL strobe_unexpected: got kind %0d addr %06h data %02h required none",
                     mon_act.kind, mon_act.addr, mon_act.data);
          end else begin
            mon_exp = exp_q.pop_front();
            if (mon_act != mon_exp) begin
              errors++;
              $display("FAIL strobe: got kind %0d addr %06h data %02h required kind %0d addr %06h data %02h",
                       mon_act.kind, mon_act.addr, mon_act.data,
                       mon_exp.kind, mon_exp.addr, mon_exp.data);
            end else begin
              $display("ok   strobe kind %0d addr %06h data %02h",
                       mon_act.kind, mon_act.addr, mon_act.data);
            end
          end
        end
      end
    join_none

    wait_clk(3);
    chk("rst_miso", {31'd0, spi_miso}, 32'd0);
    chk("rst_oe", {31'd0, spi_miso_oe}, 32'd0);
    chk("rst_addr", {8'd0, mem_addr}, 32'd0);
    chk("rst_rd_wr_bad_busy", {28'd0, mem_rd, mem_wr, bad_cmd, busy}, 32'd0);
    chk("rst_wdata", {24'd0, mem_wdata}, 32'd0);
    rst = 1'b0;
    wait_clk(HALF);

    do_read("read", 24'h000100, 4, 32'h11223344);
    do_write("write", 24'h0000F0, 4, 32'hDEADBEEF);
    do_read("wrap", 24'hFFFFFE, 4, 32'hC1C2C3C4);

    // Unsupported command: one bad_cmd pulse, nothing else, MISO never enabled.
    oe_before = oe_cnt;
    cs_low();
    exp_q.push_back(mk(K_BAD, 24'd0, 8'h00));
    spi_byte(8'h9F, 8, rx);
    for (int k = 0; k < 4; k++) spi_byte(8'h03, 8, rx);
    cs_high("badcmd");
    chk("badcmd_oe_never", oe_cnt - oe_before, 32'd0);

    // Abort mid-write: the partial second byte must not be written.
    cs_low();
    send_hdr(8'h02, 24'h000010);
    exp_q.push_back(mk(K_WR, 24'h000010, 8'hA5));
    spi_byte(8'hA5, 8, rx);
    spi_byte(8'h3C, 5, rx);
    cs_high("abort");
    do_read("after_abort", 24'h000010, 1, 32'hA5000000);

    // Reset during byte 2 of a read.
    cs_low();
    exp_q.push_back(mk(K_RD, 24'h000100, 8'h00));
    send_hdr(8'h03, 24'h000100);
    exp_q.push_back(mk(K_RD, 24'h000101, 8'h00));
    spi_byte(8'h00, 8, rx);
    chk("rstread_byte1", {24'd0, rx}, 32'h11);
    spi_byte(8'h00, 4, rx);
    wait_clk(2);
    chk("rstread_oe_before", {31'd0, spi_miso_oe}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rstread_addr", {8'd0, mem_addr}, 32'd0);
    chk("rstread_wdata", {24'd0, mem_wdata}, 32'd0);
    chk("rstread_outs", {26'd0, spi_miso, spi_miso_oe, mem_rd, mem_wr, bad_cmd, busy}, 32'd0);
    wait_clk(3);
    rst = 1'b0;
    exp_q.delete();
    wait_clk(HALF);
    spi_cs_n = 1'b1;
    wait_clk(HALF);
    do_read("after_reset", 24'h000100, 4, 32'h11223344);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
